// File: rtl/rgb_pattern_gen.sv
// rtl/rgb_pattern_gen.sv - frame-based RGB test pattern source (solid, h-ramp, colour bars, checker)
// Optional checker pattern for mode 3 enabled by defining RGB_PATTERN_CHECKER_EN.
module rgb_pattern_gen #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int H_ACTIVE      = 16,
  parameter int V_ACTIVE      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [CHANNEL_WIDTH-1:0] solid_r,
  input  logic [CHANNEL_WIDTH-1:0] solid_g,
  input  logic [CHANNEL_WIDTH-1:0] solid_b,
  output logic [CHANNEL_WIDTH-1:0] outp_r,
  output logic [CHANNEL_WIDTH-1:0] outp_g,
  output logic [CHANNEL_WIDTH-1:0] outp_b,
  output logic                     outp_valid,
  input  logic                     outp_ready,
  output logic                     outp_sof,
  output logic                     outp_eol
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int RW = XW + CHANNEL_WIDTH;
  localparam int BW = XW + 3;
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [RW-1:0] RAMP_DIV = RW'(H_ACTIVE);
  localparam logic [BW-1:0] BAR_DIV  = BW'(H_ACTIVE);

  typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

  state_t                   state;
  logic [XW-1:0]            x;
  logic [YW-1:0]            y;
  logic [1:0]               mode_q;
  logic [CHANNEL_WIDTH-1:0] sol_r, sol_g, sol_b;
  logic                     xfer;

  assign xfer = outp_valid && outp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      outp_valid <= 1'b0;
      mode_q     <= '0;
      sol_r      <= '0;
      sol_g      <= '0;
      sol_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state      <= ACTIVE;
            outp_valid <= 1'b1;
            x          <= '0;
            y          <= '0;
            mode_q     <= mode;
            sol_r      <= solid_r;
            sol_g      <= solid_g;
            sol_b      <= solid_b;
          end
        end
        ACTIVE: begin
          if (xfer) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y <= '0;
                // Back-to-back frame: relatch the pattern selection with no bubble.
                if (enable) begin
                  mode_q <= mode;
                  sol_r  <= solid_r;
                  sol_g  <= solid_g;
                  sol_b  <= solid_b;
                end else begin
                  state      <= IDLE;
                  outp_valid <= 1'b0;
                end
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [RW-1:0]            ramp_num;
  logic [CHANNEL_WIDTH-1:0] ramp;
  logic [BW-1:0]            bar_num;
  logic [2:0]               bar;
  logic [CHANNEL_WIDTH-1:0] pix_r, pix_g, pix_b;

  // Widened numerators keep x * 2^CHANNEL_WIDTH and x * 8 exact before dividing.
  assign ramp_num = {x, {CHANNEL_WIDTH{1'b0}}};
  assign ramp     = CHANNEL_WIDTH'(ramp_num / RAMP_DIV);
  assign bar_num  = {x, 3'b000};
  assign bar      = 3'(bar_num / BAR_DIV);

  always_comb begin
    pix_r = sol_r;
    pix_g = sol_g;
    pix_b = sol_b;
    case (mode_q)
      2'd1: begin
        pix_r = ramp;
        pix_g = ramp;
        pix_b = ramp;
      end
      2'd2: begin
        pix_r = {CHANNEL_WIDTH{bar[2]}};
        pix_g = {CHANNEL_WIDTH{bar[1]}};
        pix_b = {CHANNEL_WIDTH{bar[0]}};
      end
`ifdef RGB_PATTERN_CHECKER_EN
      2'd3: begin
        pix_r = {CHANNEL_WIDTH{x[0] ^ y[0]}};
        pix_g = {CHANNEL_WIDTH{x[0] ^ y[0]}};
        pix_b = {CHANNEL_WIDTH{x[0] ^ y[0]}};
      end
`endif
      default: ;
    endcase
  end

  assign outp_r   = outp_valid ? pix_r : {CHANNEL_WIDTH{1'bx}};
  assign outp_g   = outp_valid ? pix_g : {CHANNEL_WIDTH{1'bx}};
  assign outp_b   = outp_valid ? pix_b : {CHANNEL_WIDTH{1'bx}};
  assign outp_sof = outp_valid && (x == '0) && (y == '0);
  assign outp_eol = outp_valid && (x == X_LAST);

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// tb/tb_rgb_pattern_gen.sv - randomized bench for rgb_pattern_gen against a pixel-index reference model
module tb_rgb_pattern_gen;
  localparam int CW   = 8;
  localparam int H    = 16;
  localparam int V    = 4;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic [CW-1:0] solid_r, solid_g, solid_b;
  logic [CW-1:0] outp_r, outp_g, outp_b;
  logic          outp_valid, outp_ready, outp_sof, outp_eol;

  always #5 clk = ~clk;

  rgb_pattern_gen #(.CHANNEL_WIDTH(CW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
    .outp_r(outp_r), .outp_g(outp_g), .outp_b(outp_b),
    .outp_valid(outp_valid), .outp_ready(outp_ready),
    .outp_sof(outp_sof), .outp_eol(outp_eol)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame = NPIX pixels indexed by pidx; x/y derived arithmetically.
  bit m_idle = 1'b1;
  int pidx   = 0;
  int f_mode, f_r, f_g, f_b;
  int xfers = 0, sofs = 0, eols = 0;

  function automatic int exp_chan(input int ch, input int p);
    int px, py, ones, bar;
    px   = p % H;
    py   = p / H;
    ones = (1 << CW) - 1;
    if (f_mode == 1) return (px * (1 << CW)) / H;
    if (f_mode == 2) begin
      bar = (px * 8) / H;
      return ((bar >> (2 - ch)) & 1) ? ones : 0;
    end
`ifdef RGB_PATTERN_CHECKER_EN
    if (f_mode == 3) return ((px ^ py) & 1) ? ones : 0;
`endif
    return (ch == 0) ? f_r : (ch == 1) ? f_g : f_b;
  endfunction

  task automatic capture();
    f_mode = int'(mode);
    f_r    = int'(solid_r);
    f_g    = int'(solid_g);
    f_b    = int'(solid_b);
  endtask

  task automatic model_eval();
    if (m_idle) begin
      check("idle_valid", outp_valid, 0);
      if (enable) begin
        capture();
        m_idle = 1'b0;
        pidx   = 0;
      end
    end else begin
      check("valid", outp_valid, 1);
      check("r", outp_r, exp_chan(0, pidx));
      check("g", outp_g, exp_chan(1, pidx));
      check("b", outp_b, exp_chan(2, pidx));
      check("sof", outp_sof, pidx == 0);
      check("eol", outp_eol, (pidx % H) == H - 1);
      if (outp_ready) begin
        xfers++;
        if (outp_sof) sofs++;
        if (outp_eol) eols++;
        pidx++;
        if (pidx == NPIX) begin
          if (enable) begin
            capture();
            pidx = 0;
          end else begin
            m_idle = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [CW-1:0] r, g, b);
    int x0, s0, e0;
    x0 = xfers; s0 = sofs; e0 = eols;
    mode = m; solid_r = r; solid_g = g; solid_b = b;
    outp_ready = 1'b1;
    enable     = 1'b1;
    step();
    enable = 1'b0;
    repeat (NPIX + 4) step();
    check("frame_xfers", xfers - x0, NPIX);
    check("frame_sofs", sofs - s0, 1);
    check("frame_eols", eols - e0, V);
    check("frame_idle", m_idle, 1);
  endtask

  initial begin
    bit found;
    rst = 1'b0; enable = 1'b0; mode = 2'd0; outp_ready = 1'b0;
    solid_r = '0; solid_g = '0; solid_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", outp_valid, 0);
    check("rst_sof", outp_sof, 0);
    check("rst_eol", outp_eol, 0);
    rst = 1'b1;

    run_frame(2'd0, 8'h10, 8'h11, 8'h12);
    run_frame(2'd1, 8'h00, 8'h00, 8'h00);
    run_frame(2'd2, 8'h00, 8'h00, 8'h00);
    run_frame(2'd3, 8'h5A, 8'hA5, 8'h3C);

    for (int i = 0; i < 3000; i++) begin
      outp_ready = ($urandom_range(0, 9) < 7);
      enable     = ($urandom_range(0, 7) != 0);
      mode       = 2'($urandom_range(0, 3));
      solid_r    = CW'($urandom);
      solid_g    = CW'($urandom);
      solid_b    = CW'($urandom);
      step();
    end
    enable = 1'b0;
    outp_ready = 1'b1;
    repeat (NPIX + 4) step();
    check("drain_idle", m_idle, 1);

    mode = 2'd0; solid_r = 8'h21; solid_g = 8'h43; solid_b = 8'h65;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (!m_idle && pidx == 20) found = 1'b1;
    end
    check("reach_pixel20", found, 1);
    rst = 1'b0;
    #2;
    check("async_valid", outp_valid, 0);
    check("async_sof", outp_sof, 0);
    check("async_eol", outp_eol, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("held_valid", outp_valid, 0);
    rst = 1'b1;
    m_idle = 1'b1;
    pidx = 0;
    run_frame(2'd0, 8'h21, 8'h43, 8'h65);

    check("xfers_total", xfers > 500, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_pattern_gen.md
RGB_PATTERN_GEN -- requirements
Module: rgb_pattern_gen

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 8: bit width of each of the r, g, b channels.
REQ-002 SHALL have parameter H_ACTIVE, default 16: pixels per line, at least 2.
REQ-003 SHALL have parameter V_ACTIVE, default 4: lines per frame, at least 1.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1: when high, a new frame starts after the current frame ends.
REQ-007 SHALL have port mode, input, 2: pattern select, 0=solid, 1=h-ramp, 2=colour bars, 3=checker.
REQ-008 SHALL have ports solid_r, solid_g, solid_b, input, CHANNEL_WIDTH each: colour used by solid mode.
REQ-009 SHALL have ports outp_r, outp_g, outp_b, output, CHANNEL_WIDTH each: pixel colour.
REQ-010 SHALL have port outp_valid, output, 1: a pixel is presented on the outputs.
REQ-011 SHALL have port outp_ready, input, 1: the sink accepts the pixel.
REQ-012 SHALL have ports outp_sof and outp_eol, output, 1 each: first pixel of the frame, and last pixel of a line.

Function
REQ-013 SHALL define a transfer as outp_valid=1 and outp_ready=1 in the same cycle.
REQ-014 SHALL hold all outp_* outputs stable while outp_valid=1 and outp_ready=0.
REQ-015 SHALL run the FSM states IDLE -> ACTIVE -> IDLE.
- IDLE->ACTIVE when enable=1; outp_valid asserts in the next cycle.
- ACTIVE->IDLE on transfer of the last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1) when enable=0.
- If enable=1 at that transfer, the next frame follows back-to-back with no bubble.
REQ-016 SHALL keep counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1), both 0 on frame entry.
- x increments on each transfer and wraps to 0 at H_ACTIVE-1, at which point y increments.
- y wraps to 0 at V_ACTIVE-1.
REQ-017 SHALL sample mode and solid_* at frame start only; changes mid-frame take effect from the next frame.
REQ-018 SHALL assert outp_sof while x=0 and y=0, and outp_eol while x=H_ACTIVE-1, both only when outp_valid=1.
REQ-019 Solid mode: outp = the latched solid_r, solid_g, solid_b.
REQ-020 H-ramp mode: outp_r = outp_g = outp_b = (x * 2^CHANNEL_WIDTH) / H_ACTIVE, truncated, computed at full precision with no overflow.
REQ-021 Colour-bar mode: bar = (x*8)/H_ACTIVE, giving 0..7.
- Channel r = all-ones if bar bit2, else 0; g uses bar bit1; b uses bar bit0.
REQ-022 SHALL drive outp_r, outp_g, outp_b to all-X when outp_valid=0, matching the codebase's X-default for undriven composites.
REQ-023 Dropping enable mid-frame SHALL NOT truncate the frame; the frame always completes.

Reset
REQ-024 On rst=0, SHALL immediately force FSM=IDLE, x=0, y=0, outp_valid=0, outp_sof=0, outp_eol=0, and zero the latched mode and colour.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, the next frame starts from x=0, y=0.

Configuration
REQ-026 With RGB_PATTERN_CHECKER_EN defined, mode 3 SHALL output all-ones on all channels when (x[0] XOR y[0])=1, and 0 otherwise.
REQ-027 Without RGB_PATTERN_CHECKER_EN, mode 3 SHALL behave exactly as mode 0 (solid), and no checker logic SHALL be synthesised.

Verification
REQ-028 Defaults, mode 0, solid=(0x10, 0x11, 0x12), enable=1, outp_ready=1 -> 64 transfers of (0x10, 0x11, 0x12); sof on transfer 1, eol on transfers 16, 32, 48, 64.
REQ-029 Mode 1, H_ACTIVE=16 -> r=g=b sequence 0x00, 0x10, ... 0xF0 repeating on every line.
REQ-030 Mode 2 -> x=0..1 gives (0, 0, 0); x=2..3 gives (0, 0, 0xFF); x=14..15 gives (0xFF, 0xFF, 0xFF).
REQ-031 outp_ready toggled pseudo-randomly -> outputs stable while stalled; no pixel lost or duplicated; x/y sequence identical to the no-stall case.
REQ-032 rst pulsed low at pixel 20 -> all outputs reset asynchronously; the restarted frame begins with sof at x=0, y=0.
REQ-033 Mode 3 with the macro defined -> pixel (0,0)=0x00 and pixel (1,0)=0xFF; without the macro -> output equals the solid colour.
